// File: rtl/pipelined_adder.sv
// -----------------------------------------------------------------------------
// pipelined_adder
//
// Purpose:
//   WIDTH-bit add/subtract split into CHUNK-bit slices, one slice per pipeline
//   stage. The carry ripples from stage to stage. Operand slices that are not
//   yet added travel skewed in the stage registers, and finished sum slices are
//   carried forward unchanged. Sustains one operation per cycle and produces
//   result, carry-out and signed overflow. Latency is STAGES cycles when there
//   is no stall.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst_n      in   synchronous active-low reset
//   in_valid   in   operand bundle valid
//   in_ready   out  bundle can be accepted this cycle
//   operand0   in   WIDTH  first operand (a)
//   operand1   in   WIDTH  second operand
//   sub        in   1: operand0 - operand1, 0: operand0 + operand1
//   out_valid  out  result bundle valid
//   out_ready  in   consumer takes the bundle this cycle
//   result     out  WIDTH  sum/difference mod 2^WIDTH (0 while !out_valid)
//   carry_out  out  carry out of bit WIDTH-1 (sub: 1 = no borrow)
//   overflow   out  signed two's-complement overflow
//
// Handshake: a bundle moves on a side when valid & ready are both high in the
// same cycle. The producer holds in_valid and its data stable until in_ready.
// out_valid, result, carry_out and overflow hold while out_valid & !out_ready.
// The whole pipeline advances together (advance = !out_valid | out_ready), so
// in_ready = advance and bubbles are not squeezed out.
// -----------------------------------------------------------------------------
module pipelined_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand0,
    input  logic [WIDTH-1:0] operand1,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int STAGES = WIDTH / CHUNK;

    logic             w_advance;
    logic [WIDTH-1:0] w_b_eff;

    // Stage registers. r_b holds the effective (possibly inverted) operand so
    // the final stage can derive overflow from its sign bit.
    logic [STAGES-1:0] r_valid;
    logic [WIDTH-1:0]  r_a     [STAGES];
    logic [WIDTH-1:0]  r_b     [STAGES];
    logic [WIDTH-1:0]  r_sum   [STAGES];
    logic              r_carry [STAGES];

    // Inputs seen by each stage: stage 0 takes the port bundle, stage k takes
    // the registers of stage k-1.
    logic [WIDTH-1:0]  w_in_a   [STAGES];
    logic [WIDTH-1:0]  w_in_b   [STAGES];
    logic [WIDTH-1:0]  w_in_sum [STAGES];
    logic              w_in_c   [STAGES];

    logic [CHUNK:0]    w_slice    [STAGES];
    logic [WIDTH-1:0]  w_sum_next [STAGES];

    assign w_advance = !out_valid || out_ready;
    assign in_ready  = w_advance;

    // Subtraction is a + ~b + 1; the +1 enters as the carry into bit 0.
    assign w_b_eff = sub ? ~operand1 : operand1;

    always_comb begin
        w_in_a[0]   = operand0;
        w_in_b[0]   = w_b_eff;
        w_in_sum[0] = '0;
        w_in_c[0]   = sub;
        for (int k = 1; k < STAGES; k++) begin
            w_in_a[k]   = r_a[k-1];
            w_in_b[k]   = r_b[k-1];
            w_in_sum[k] = r_sum[k-1];
            w_in_c[k]   = r_carry[k-1];
        end
    end

    // Stage k adds slice k and patches it into the partial sum; the top bit of
    // the slice sum is the carry handed to stage k+1.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_slice[k] = {1'b0, w_in_a[k][k*CHUNK +: CHUNK]}
                       + {1'b0, w_in_b[k][k*CHUNK +: CHUNK]}
                       + {{CHUNK{1'b0}}, w_in_c[k]};
            w_sum_next[k] = w_in_sum[k];
            w_sum_next[k][k*CHUNK +: CHUNK] = w_slice[k][CHUNK-1:0];
        end
    end

    // Valid bits are the only reset state; in-flight ops vanish on reset.
    // in_ready equals advance, so inside the advance branch in_valid alone
    // marks an accepted bundle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (w_advance) begin
            r_valid[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                r_valid[k] <= r_valid[k-1];
            end
        end
    end

    // Data registers need no reset: the outputs are masked by out_valid.
    always_ff @(posedge clk) begin
        if (w_advance) begin
            for (int k = 0; k < STAGES; k++) begin
                r_a[k]     <= w_in_a[k];
                r_b[k]     <= w_in_b[k];
                r_sum[k]   <= w_sum_next[k];
                r_carry[k] <= w_slice[k][CHUNK];
            end
        end
    end

    assign out_valid = r_valid[STAGES-1];
    assign result    = out_valid ? r_sum[STAGES-1] : '0;
    assign carry_out = out_valid & r_carry[STAGES-1];
    // Overflow: both addends share a sign and the sum's sign differs from it.
    assign overflow  = out_valid
                     & (r_a[STAGES-1][WIDTH-1] == r_b[STAGES-1][WIDTH-1])
                     & (r_sum[STAGES-1][WIDTH-1] != r_a[STAGES-1][WIDTH-1]);

endmodule

// File: tb/tb_pipelined_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_adder
//
// Main instance: WIDTH=32, CHUNK=8. Covers reset values, a table of directed
// vectors with a latency check, backpressure, reset while ops are in flight,
// and a random stream. Two 8-bit instances (CHUNK=4 and CHUNK=8) run corner
// pairs plus random pairs in parallel with random out_ready. Expected results
// come from a signed/unsigned integer model of add/subtract.
// -----------------------------------------------------------------------------
module tb_pipelined_adder;

    // ---------------- clock / reset ----------------
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] operand0;
    logic [31:0] operand1;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        carry_out;
    logic        overflow;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(32), .CHUNK(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operand0  (operand0),
        .operand1  (operand1),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    // ---------------- bookkeeping ----------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference: plain integer arithmetic on a w-bit machine.
    // Returns {carry_out, overflow, result[31:0]}.
    function automatic logic [33:0] ref_model(input int w, input longint ua,
                                              input longint ub, input bit s);
        longint m, half, sa, sb, sr, ur;
        bit cy, ov;
        logic [31:0] r32;
        m    = longint'(1) << w;
        half = m / 2;
        sa   = (ua >= half) ? ua - m : ua;
        sb   = (ub >= half) ? ub - m : ub;
        sr   = s ? sa - sb : sa + sb;
        ov   = (sr >= half) || (sr < -half);
        cy   = s ? (ua >= ub) : ((ua + ub) >= m);
        ur   = s ? ua - ub : ua + ub;
        if (ur < 0)  ur = ur + m;
        if (ur >= m) ur = ur - m;
        r32  = ur[31:0];
        return {cy, ov, r32};
    endfunction

    // ---------------- scoreboard for the main instance ----------------
    logic [33:0] exp_q[$];
    logic [33:0] last_got;
    logic [33:0] held;
    bit          hold_pending = 1'b0;

    // One cycle: drive at negedge, sample 1 time unit later, score outputs,
    // record an accept for the coming posedge.
    task automatic step_main(input bit iv, input logic [31:0] a, input logic [31:0] b,
                             input bit s, input bit ordy, input bit rstn,
                             output bit acc, output bit emit);
        logic [33:0] got;
        logic [33:0] e;
        @(negedge clk);
        rst_n     = rstn;
        in_valid  = iv;
        operand0  = a;
        operand1  = b;
        sub       = s;
        out_ready = ordy;
        #1;
        acc  = iv && in_ready;
        emit = out_valid && out_ready;
        got  = {carry_out, overflow, result};
        if (hold_pending) check("hold_stable", {out_valid, got}, {1'b1, held});
        if (emit) begin
            last_got = got;
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL spurious_out: got 0x%0h, expected no output", got);
            end else begin
                e = exp_q.pop_front();
                check("stream_out", got, e);
            end
        end
        hold_pending = out_valid && !out_ready;
        held         = got;
        if (acc) exp_q.push_back(ref_model(32, longint'(a), longint'(b), s));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        bit          s;
        logic [31:0] res;
        bit          c;
        bit          o;
    } vec_t;

    localparam int N_DIR = 10;
    vec_t vecs[N_DIR];

    // ---------------- 8-bit instances ----------------
    function automatic logic [7:0] corner8(input int i);
        case (i)
            0: corner8 = 8'h00;
            1: corner8 = 8'h01;
            2: corner8 = 8'h7E;
            3: corner8 = 8'h7F;
            4: corner8 = 8'h80;
            5: corner8 = 8'h81;
            default: corner8 = 8'hFF;
        endcase
    endfunction

    localparam int N_CORNER = 7 * 7 * 2;
    localparam int N_SMALL  = N_CORNER + 3000;

    for (genvar g = 0; g < 2; g++) begin : g_small
        localparam int CH = (g == 0) ? 4 : 8;
        logic       s_rst_n, s_in_valid, s_in_ready, s_sub;
        logic       s_out_valid, s_out_ready, s_c, s_o;
        logic [7:0] s_a, s_b, s_res;
        logic [9:0] s_q[$];
        bit         s_done = 1'b0;

        pipelined_adder #(.WIDTH(8), .CHUNK(CH)) u_small (
            .clk       (clk),
            .rst_n     (s_rst_n),
            .in_valid  (s_in_valid),
            .in_ready  (s_in_ready),
            .operand0  (s_a),
            .operand1  (s_b),
            .sub       (s_sub),
            .out_valid (s_out_valid),
            .out_ready (s_out_ready),
            .result    (s_res),
            .carry_out (s_c),
            .overflow  (s_o)
        );

        initial begin : small_run
            logic [7:0]  cur_a, cur_b;
            bit          cur_s;
            int          idx;
            bit          held_p;
            logic [9:0]  s_held, got, e;
            logic [33:0] m;
            s_rst_n = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0;
            s_a = '0; s_b = '0; s_sub = 1'b0;
            idx = 0; held_p = 1'b0; s_held = '0;
            cur_a = corner8(0); cur_b = corner8(0); cur_s = 1'b0;
            repeat (3) @(negedge clk);
            s_rst_n = 1'b1;
            for (int cyc = 0; cyc < 20000 && (idx < N_SMALL || s_q.size() != 0); cyc++) begin
                @(negedge clk);
                s_in_valid  = (idx < N_SMALL) && ($urandom_range(0, 7) != 0);
                s_out_ready = ($urandom_range(0, 3) != 0);
                s_a = cur_a; s_b = cur_b; s_sub = cur_s;
                #1;
                got = {s_c, s_o, s_res};
                if (held_p) check("small_hold", {s_out_valid, got}, {1'b1, s_held});
                if (s_out_valid && s_out_ready) begin
                    if (s_q.size() == 0) begin
                        n_total++;
                        $display("FAIL small_spurious: got 0x%0h, expected no output", got);
                    end else begin
                        e = s_q.pop_front();
                        check("small_out", got, e);
                    end
                end
                held_p = s_out_valid && !s_out_ready;
                s_held = got;
                if (s_in_valid && s_in_ready) begin
                    m = ref_model(8, longint'(cur_a), longint'(cur_b), cur_s);
                    s_q.push_back({m[33:32], m[7:0]});
                    idx++;
                    if (idx < N_CORNER) begin
                        cur_a = corner8((idx / 14) % 7);
                        cur_b = corner8((idx / 2) % 7);
                        cur_s = bit'(idx % 2);
                    end else begin
                        cur_a = 8'($urandom());
                        cur_b = 8'($urandom());
                        cur_s = bit'($urandom_range(0, 1));
                    end
                end
            end
            check("small_issued", idx, N_SMALL);
            check("small_drained", s_q.size(), 0);
            s_in_valid = 1'b0;
            s_done = 1'b1;
        end
    end

    // ---------------- main test ----------------
    initial begin : main_run
        bit          acc, emit;
        int          lat, issued, n_emit, n_done;
        bit          seen;
        logic [31:0] ra, rb;
        bit          rs;

        vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[2] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[4] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        vecs[5] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[6] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
        vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[8] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b0, 1'b1};
        vecs[9] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        operand0 = '0; operand1 = '0; sub = 1'b0;

        // Reset values, sampled while reset is held.
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_result", result, 32'h0);
        check("rst_carry", carry_out, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);

        // Directed vectors, one at a time, with latency measurement.
        for (int i = 0; i < N_DIR; i++) begin
            step_main(1'b1, vecs[i].a, vecs[i].b, vecs[i].s, 1'b1, 1'b1, acc, emit);
            check("dir_accept", acc, 1'b1);
            lat = 0; seen = 1'b0;
            for (int c = 1; c <= 12 && !seen; c++) begin
                step_main(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, acc, emit);
                if (emit) begin seen = 1'b1; lat = c; end
            end
            check("dir_latency", lat, 4);
            check("dir_value", last_got, {vecs[i].c, vecs[i].o, vecs[i].res});
        end

        // Backpressure: 6 back-to-back ops, out_ready low in cycles 5..8.
        issued = 0; n_emit = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            step_main(issued < 6, 32'(issued + 1), 32'(issued) * 32'h0101_0101, 1'b0,
                      !(cyc >= 5 && cyc <= 8), 1'b1, acc, emit);
            if (acc)  issued++;
            if (emit) n_emit++;
            if (cyc >= 5 && cyc <= 8) check("bp_in_ready_low", in_ready, 1'b0);
        end
        check("bp_issued", issued, 6);
        check("bp_emitted", n_emit, 6);
        check("bp_queue_empty", exp_q.size(), 0);

        // Reset while three ops are in flight.
        step_main(1'b1, 32'd1, 32'd2, 1'b0, 1'b1, 1'b1, acc, emit);
        step_main(1'b1, 32'd3, 32'd4, 1'b0, 1'b1, 1'b1, acc, emit);
        step_main(1'b1, 32'd5, 32'd6, 1'b1, 1'b1, 1'b0, acc, emit);
        exp_q.delete();
        hold_pending = 1'b0;
        for (int cyc = 3; cyc <= 10; cyc++) begin
            step_main(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, acc, emit);
            check("rstmid_out_valid", out_valid, 1'b0);
            check("rstmid_in_ready", in_ready, 1'b1);
        end

        // Random stream with bubbles and random backpressure.
        n_done = 0;
        ra = $urandom(); rb = $urandom(); rs = bit'($urandom_range(0, 1));
        for (int cyc = 0; cyc < 4000 && (n_done < 300 || exp_q.size() != 0); cyc++) begin
            step_main((n_done < 300) && ($urandom_range(0, 3) != 0), ra, rb, rs,
                      $urandom_range(0, 3) != 0, 1'b1, acc, emit);
            if (acc) begin
                n_done++;
                ra = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom();
                rb = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom();
                rs = bit'($urandom_range(0, 1));
            end
        end
        check("rand_issued", n_done, 300);
        check("rand_drained", exp_q.size(), 0);
        in_valid = 1'b0;

        // Wait for the 8-bit instances, bounded.
        for (int t = 0; t < 30000 && !(g_small[0].s_done && g_small[1].s_done); t++)
            @(negedge clk);
        check("small_finished", {g_small[0].s_done, g_small[1].s_done}, 2'b11);

        $display("%0d/%0d checks passed", n_pass, n_total);
        if (n_pass == n_total) $display("Testbench Succeeded!");
        $finish;
    end

endmodule
